// File: rtl/qspi_pkg.sv
// Shared constants and types for the QSPI device-side interface.
// Holds tristate patterns, the frame state enum and small lane helpers.
package qspi_pkg;

    localparam logic [3:0] TRIS_IDLE   = 4'b1111;
    localparam logic [3:0] TRIS_X1     = 4'b1101;
    localparam logic [3:0] TRIS_X4_OUT = 4'b0000;

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_e;

    // Tristate pattern for the latched lane mode.
    function automatic logic [3:0] tris_for(input logic quad,
                                            input logic qtx);
        if (!quad)
            return TRIS_X1;
        else if (qtx)
            return TRIS_X4_OUT;
        else
            return TRIS_IDLE;
    endfunction

    // Pin value for the top nibble of the tx shifter.
    function automatic logic [3:0] drive_val(input logic       quad,
                                             input logic [3:0] hi);
        return quad ? hi : {2'b00, hi[3], 1'b0};
    endfunction

endpackage

// File: rtl/qspi_input_sync.sv
// Multi-flop synchronizer for asynchronous pin inputs.
// Each bit resets to its own value from RST_VAL.
module qspi_input_sync #(
    parameter int               WIDTH   = 1,
    parameter int               STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // Shift the pin value through the flop chain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < STAGES; i++)
                stage_q[i] <= RST_VAL;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++)
                stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/qspi_device_interface.sv
// QSPI device (target) front end: mode 0, x1 or x4 lanes.
// Oversamples SCK/CS/DQ in the clk domain and moves whole bytes.
module qspi_device_interface
    import qspi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       qspi_cs_n,
    input  logic       qspi_sck,
    input  logic [3:0] qspi_dq_in,
    output logic [3:0] qspi_dq_out,
    output logic [3:0] qspi_dq_tris,
    input  logic       quad_mode,
    input  logic       quad_tx,
    output logic       frame_start,
    output logic       frame_end,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic [7:0] tx_data,
    output logic       tx_req
);

    // Sync reset image: {cs_n, sck, dq[3:0]} = idle bus.
    localparam logic [5:0] SYNC_RST = 6'b10_0000;

    logic [5:0] pins_s;
    logic       cs_s, sck_s;
    logic [3:0] dq_s;

    qspi_input_sync #(
        .WIDTH   (6),
        .STAGES  (SYNC_STAGES),
        .RST_VAL (SYNC_RST)
    ) u_sync (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .d_i    ({qspi_cs_n, qspi_sck, qspi_dq_in}),
        .q_o    (pins_s)
    );

    assign cs_s  = pins_s[5];
    assign sck_s = pins_s[4];
    assign dq_s  = pins_s[3:0];

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] flush_q;
    logic                   armed_q;
    logic                   sck_q;
    logic                   quad_q, qtx_q;
    logic [3:0]             cnt_q;
    logic [6:0]             rx_sh_q;
    logic [7:0]             tx_sh_q;
    logic [7:0]             rx_data_q;
    logic [3:0]             dq_out_q, tris_q;
    logic                   rx_valid_q, tx_req_q;
    logic                   fstart_q, fend_q;

    logic       start, stop, rise_en, fall_en;
    logic       sck_rise, sck_fall, byte_done;
    logic [3:0] step, cnt_nxt;
    logic [7:0] rx_nxt;

    assign sck_rise  = sck_s & ~sck_q;
    assign sck_fall  = ~sck_s & sck_q;
    assign step      = quad_q ? 4'd4 : 4'd1;
    assign cnt_nxt   = cnt_q + step;
    assign byte_done = rise_en && (cnt_nxt == 4'd8);
    assign rx_nxt    = quad_q ? {rx_sh_q[3:0], dq_s}
                              : {rx_sh_q, dq_s[0]};

    // Frame FSM: CS level decides; SCK edges only count while active.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        stop    = 1'b0;
        rise_en = 1'b0;
        fall_en = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (armed_q && !cs_s) begin
                    state_d = ST_ACTIVE;
                    start   = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (cs_s) begin
                    state_d = ST_IDLE;
                    stop    = 1'b1;
                end else begin
                    rise_en = sck_rise;
                    fall_en = sck_fall;
                end
            end
        endcase
    end

    // State register plus arming: CS must be seen high once the
    // synchronizer has flushed, so a CS held low through reset is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            flush_q <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            flush_q <= {flush_q[SYNC_STAGES-2:0], 1'b1};
            if (flush_q[SYNC_STAGES-1] && cs_s)
                armed_q <= 1'b1;
        end
    end

    // Datapath: rx/tx shifters, bit count, lane mode and pin drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_q      <= 1'b0;
            quad_q     <= 1'b0;
            qtx_q      <= 1'b0;
            cnt_q      <= '0;
            rx_sh_q    <= '0;
            tx_sh_q    <= '0;
            rx_data_q  <= '0;
            dq_out_q   <= '0;
            tris_q     <= TRIS_IDLE;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            fstart_q   <= 1'b0;
            fend_q     <= 1'b0;
        end else begin
            sck_q      <= sck_s;
            fstart_q   <= start;
            fend_q     <= stop;
            rx_valid_q <= byte_done;
            tx_req_q   <= (fstart_q | rx_valid_q) &&
                          (state_q == ST_ACTIVE) && !cs_s;
            if (start) begin
                quad_q   <= quad_mode;
                qtx_q    <= quad_tx;
                cnt_q    <= '0;
                rx_sh_q  <= '0;
                tx_sh_q  <= quad_mode ? {tx_data[3:0], 4'b0000}
                                      : {tx_data[6:0], 1'b0};
                dq_out_q <= drive_val(quad_mode, tx_data[7:4]);
                tris_q   <= tris_for(quad_mode, quad_tx);
            end else if (stop) begin
                cnt_q    <= '0;
                dq_out_q <= '0;
                tris_q   <= TRIS_IDLE;
            end else begin
                if (rise_en) begin
                    rx_sh_q <= rx_nxt[6:0];
                    cnt_q   <= byte_done ? 4'd0 : cnt_nxt;
                    if (byte_done) begin
                        rx_data_q <= rx_nxt;
                        tx_sh_q   <= tx_data;
                        quad_q    <= quad_mode;
                        qtx_q     <= quad_tx;
                        tris_q    <= tris_for(quad_mode, quad_tx);
                    end
                end
                if (fall_en) begin
                    dq_out_q <= drive_val(quad_q, tx_sh_q[7:4]);
                    tx_sh_q  <= quad_q ? (tx_sh_q << 4) : (tx_sh_q << 1);
                end
            end
        end
    end

    assign qspi_dq_out  = dq_out_q;
    assign qspi_dq_tris = tris_q;
    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign tx_req       = tx_req_q;
    assign frame_start  = fstart_q;
    assign frame_end    = fend_q;

endmodule

// File: tb/tb_qspi_device_interface.sv
// Directed bench for qspi_device_interface.
// Host model bit-bangs mode-0 SCK/CS/DQ; monitors log strobes.
module tb_qspi_device_interface;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       qspi_cs_n = 1'b1;
    logic       qspi_sck = 1'b0;
    logic [3:0] qspi_dq_in = 4'h0;
    logic [3:0] qspi_dq_out, qspi_dq_tris;
    logic       quad_mode = 1'b0;
    logic       quad_tx = 1'b0;
    logic       frame_start, frame_end, rx_valid, tx_req;
    logic [7:0] rx_data;
    logic [7:0] tx_data = 8'h00;

    int errs = 0;
    int nchk = 0;

    int         rx_n, txr_n, fs_n, fe_n, smp_n;
    logic [7:0] rx_log [8];
    logic [3:0] smp_dq [16];
    logic [3:0] smp_tr [16];

    always #5 clk = ~clk;

    qspi_device_interface #(.SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .qspi_cs_n    (qspi_cs_n),
        .qspi_sck     (qspi_sck),
        .qspi_dq_in   (qspi_dq_in),
        .qspi_dq_out  (qspi_dq_out),
        .qspi_dq_tris (qspi_dq_tris),
        .quad_mode    (quad_mode),
        .quad_tx      (quad_tx),
        .frame_start  (frame_start),
        .frame_end    (frame_end),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .tx_data      (tx_data),
        .tx_req       (tx_req)
    );

    // Log strobes away from the active edge.
    always @(negedge clk) begin
        if (rx_valid) begin
            if (rx_n < 8) rx_log[rx_n] = rx_data;
            rx_n++;
        end
        if (tx_req) txr_n++;
        if (frame_start) fs_n++;
        if (frame_end) fe_n++;
    end

    task automatic clear_logs();
        rx_n = 0; txr_n = 0; fs_n = 0; fe_n = 0; smp_n = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCK period; device pins sampled just before the rise.
    task automatic sck_bit(input logic [3:0] dq);
        qspi_dq_in = dq;
        idle(8);
        if (smp_n < 16) begin
            smp_dq[smp_n] = qspi_dq_out;
            smp_tr[smp_n] = qspi_dq_tris;
        end
        smp_n++;
        qspi_sck = 1'b1;
        idle(8);
        qspi_sck = 1'b0;
    endtask

    task automatic cs_low();
        qspi_cs_n = 1'b0;
        idle(8);
    endtask

    task automatic cs_high();
        idle(8);
        qspi_cs_n = 1'b1;
        idle(8);
    endtask

    task automatic send_x1(input logic [7:0] b);
        for (int i = 7; i >= 0; i--)
            sck_bit({3'b000, b[i]});
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(4);
        nchk++;
        if (qspi_dq_out !== 4'h0) begin
            errs++; $display("FAIL rst_dq_out got=%h exp=0", qspi_dq_out);
        end
        nchk++;
        if (qspi_dq_tris !== 4'hF) begin
            errs++; $display("FAIL rst_tris got=%h exp=f", qspi_dq_tris);
        end
        nchk++;
        if (rx_data !== 8'h00) begin
            errs++; $display("FAIL rst_rx_data got=%h exp=00", rx_data);
        end
        nchk++;
        if ({rx_valid, tx_req, frame_start, frame_end} !== 4'b0000) begin
            errs++;
            $display("FAIL rst_strobes got=%b exp=0000",
                     {rx_valid, tx_req, frame_start, frame_end});
        end
        rst_n = 1'b1;
        idle(8);
    endtask

    task automatic test_x1();
        logic [7:0] seq;
        logic       tr_ok;
        quad_mode = 1'b0; quad_tx = 1'b0; tx_data = 8'h3C;
        clear_logs();
        cs_low();
        send_x1(8'hA5);
        idle(8);
        seq = '0; tr_ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            seq = {seq[6:0], smp_dq[i][1]};
            if (smp_tr[i] !== 4'b1101) tr_ok = 1'b0;
        end
        cs_high();
        nchk++;
        if (rx_n !== 1) begin
            errs++; $display("FAIL x1_rx_count got=%0d exp=1", rx_n);
        end
        nchk++;
        if (rx_log[0] !== 8'hA5) begin
            errs++; $display("FAIL x1_rx_byte got=%h exp=a5", rx_log[0]);
        end
        nchk++;
        if (seq !== 8'h3C) begin
            errs++; $display("FAIL x1_dq1_seq got=%h exp=3c", seq);
        end
        nchk++;
        if (!tr_ok) begin
            errs++; $display("FAIL x1_tris got=%h exp=d", smp_tr[0]);
        end
        nchk++;
        if ({fs_n, fe_n, txr_n} !== {32'd1, 32'd1, 32'd2}) begin
            errs++;
            $display("FAIL x1_strobes got fs=%0d fe=%0d txr=%0d exp 1 1 2",
                     fs_n, fe_n, txr_n);
        end
        nchk++;
        if (qspi_dq_tris !== 4'hF) begin
            errs++; $display("FAIL x1_end_tris got=%h exp=f", qspi_dq_tris);
        end
    endtask

    task automatic test_x4_rx();
        logic tr_ok;
        quad_mode = 1'b1; quad_tx = 1'b0; tx_data = 8'h00;
        clear_logs();
        cs_low();
        sck_bit(4'hD); sck_bit(4'hE); sck_bit(4'hA); sck_bit(4'hD);
        cs_high();
        tr_ok = 1'b1;
        for (int i = 0; i < 4; i++)
            if (smp_tr[i] !== 4'hF) tr_ok = 1'b0;
        nchk++;
        if (rx_n !== 2) begin
            errs++; $display("FAIL x4rx_count got=%0d exp=2", rx_n);
        end
        nchk++;
        if ({rx_log[0], rx_log[1]} !== 16'hDEAD) begin
            errs++;
            $display("FAIL x4rx_bytes got=%h%h exp=dead", rx_log[0], rx_log[1]);
        end
        nchk++;
        if (!tr_ok) begin
            errs++; $display("FAIL x4rx_tris got=%h exp=f", smp_tr[0]);
        end
    endtask

    task automatic test_x4_tx();
        logic [15:0] seq;
        logic        tr_ok;
        quad_mode = 1'b1; quad_tx = 1'b1; tx_data = 8'h5A;
        clear_logs();
        cs_low();
        nchk++;
        if (txr_n !== 1) begin
            errs++; $display("FAIL x4tx_first_req got=%0d exp=1", txr_n);
        end
        tx_data = 8'hC3;
        for (int i = 0; i < 4; i++) sck_bit(4'h0);
        cs_high();
        seq = '0; tr_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            seq = {seq[11:0], smp_dq[i]};
            if (smp_tr[i] !== 4'h0) tr_ok = 1'b0;
        end
        nchk++;
        if (seq !== 16'h5AC3) begin
            errs++; $display("FAIL x4tx_dq_seq got=%h exp=5ac3", seq);
        end
        nchk++;
        if (!tr_ok) begin
            errs++; $display("FAIL x4tx_tris got=%h exp=0", smp_tr[0]);
        end
        nchk++;
        if (txr_n !== 3) begin
            errs++; $display("FAIL x4tx_req_count got=%0d exp=3", txr_n);
        end
    endtask

    task automatic test_abort();
        quad_mode = 1'b0; quad_tx = 1'b0;
        clear_logs();
        cs_low();
        for (int i = 0; i < 5; i++) sck_bit({3'b000, i[0]});
        cs_high();
        nchk++;
        if (rx_n !== 0) begin
            errs++; $display("FAIL abort_rx got=%0d exp=0", rx_n);
        end
        nchk++;
        if (fe_n !== 1) begin
            errs++; $display("FAIL abort_frame_end got=%0d exp=1", fe_n);
        end
        nchk++;
        if (qspi_dq_tris !== 4'hF) begin
            errs++; $display("FAIL abort_tris got=%h exp=f", qspi_dq_tris);
        end
        clear_logs();
        cs_low();
        send_x1(8'h81);
        cs_high();
        nchk++;
        if (rx_n !== 1 || rx_log[0] !== 8'h81) begin
            errs++;
            $display("FAIL abort_next got n=%0d byte=%h exp 1 81",
                     rx_n, rx_log[0]);
        end
    endtask

    task automatic test_reset_mid();
        quad_mode = 1'b0; quad_tx = 1'b0; tx_data = 8'hFF;
        cs_low();
        for (int i = 0; i < 3; i++) sck_bit(4'h1);
        rst_n = 1'b0;
        idle(2);
        nchk++;
        if ({qspi_dq_out, qspi_dq_tris, rx_data} !== 16'h0F00) begin
            errs++;
            $display("FAIL midrst_outs got dq=%h tris=%h rx=%h exp 0 f 00",
                     qspi_dq_out, qspi_dq_tris, rx_data);
        end
        nchk++;
        if ({rx_valid, tx_req, frame_start, frame_end} !== 4'b0000) begin
            errs++;
            $display("FAIL midrst_strobes got=%b exp=0000",
                     {rx_valid, tx_req, frame_start, frame_end});
        end
        rst_n = 1'b1;
        clear_logs();
        idle(8);
        send_x1(8'hFF);
        idle(8);
        nchk++;
        if ({fs_n, rx_n} !== {32'd0, 32'd0}) begin
            errs++;
            $display("FAIL midrst_no_frame got fs=%0d rx=%0d exp 0 0",
                     fs_n, rx_n);
        end
        nchk++;
        if (qspi_dq_tris !== 4'hF) begin
            errs++; $display("FAIL midrst_tris got=%h exp=f", qspi_dq_tris);
        end
        qspi_cs_n = 1'b1;
        idle(8);
        clear_logs();
        cs_low();
        send_x1(8'h5C);
        cs_high();
        nchk++;
        if (fs_n !== 1 || rx_n !== 1 || rx_log[0] !== 8'h5C) begin
            errs++;
            $display("FAIL midrst_refresh got fs=%0d n=%0d byte=%h exp 1 1 5c",
                     fs_n, rx_n, rx_log[0]);
        end
    endtask

    task automatic test_mode_switch();
        quad_mode = 1'b0; quad_tx = 1'b0; tx_data = 8'h00;
        clear_logs();
        cs_low();
        for (int i = 7; i >= 4; i--) sck_bit(4'h0);
        quad_mode = 1'b1;
        sck_bit(4'h0); sck_bit(4'h0); sck_bit(4'h0); sck_bit(4'h1);
        sck_bit(4'h7); sck_bit(4'hE);
        cs_high();
        nchk++;
        if (rx_n !== 2) begin
            errs++; $display("FAIL mode_rx_count got=%0d exp=2", rx_n);
        end
        nchk++;
        if ({rx_log[0], rx_log[1]} !== 16'h017E) begin
            errs++;
            $display("FAIL mode_bytes got=%h%h exp=017e", rx_log[0], rx_log[1]);
        end
        nchk++;
        if ({smp_tr[7], smp_tr[9]} !== 8'hDF) begin
            errs++;
            $display("FAIL mode_tris got=%h%h exp=df", smp_tr[7], smp_tr[9]);
        end
    endtask

    initial begin
        clear_logs();
        test_reset();
        test_x1();
        test_x4_rx();
        test_x4_tx();
        test_abort();
        test_reset_mid();
        test_mode_switch();
        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule

// File: doc/qspi_device_interface.md
QSPI_DEVICE_INTERFACE -- requirements
Module: qspi_device_interface

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on every pin input (min 2).
REQ-002 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port qspi_cs_n  input  1  chip select from host, active-low.
REQ-005 SHALL have port qspi_sck  input  1  serial clock from host, mode 0.
REQ-006 SHALL have port qspi_dq_in  input  4  DQ pin inputs.
REQ-007 SHALL have port qspi_dq_out  output  4  DQ output values.
REQ-008 SHALL have port qspi_dq_tris  output  4  per-bit tristate; 1 = hi-Z.
REQ-009 SHALL have port quad_mode  input  1  1 = x4 transfers; sampled only at frame start and byte boundaries.
REQ-010 SHALL have port quad_tx  input  1  in x4, 1 = device drives DQ[3:0]; sampled with quad_mode.
REQ-011 SHALL have ports frame_start / frame_end  output  1 each  one-cycle pulses on CS assert / deassert.
REQ-012 SHALL have ports rx_valid  output  1 and rx_data  output  8  received byte, rx_data held until next rx_valid.
REQ-013 SHALL have ports tx_data  input  8 and tx_req  output  1  next transmit byte; tx_req pulses after each capture.

Function
REQ-014 SHALL synchronize qspi_cs_n, qspi_sck, qspi_dq_in through SYNC_STAGES flops; clk SHALL be >= 8x SCK (half-period >= 4 clk).
REQ-015 SHALL detect SCK rise/fall as 0->1 / 1->0 of the synchronized SCK versus its one-cycle-delayed copy ("detect cycle").
REQ-016 States: IDLE (CS deasserted), ACTIVE (CS asserted); IDLE->ACTIVE on synchronized CS_n falling, ACTIVE->IDLE on rising.
REQ-017 On IDLE->ACTIVE: frame_start pulse, bit count 0, latch quad_mode/quad_tx, capture tx_data into tx shift register, drive MSB, tx_req pulse next cycle.
REQ-018 x1: sample DQ[0] on SCK rise MSB-first; drive tx bit on DQ[1], tris 4'b1101.
REQ-019 x4: sample DQ[3:0] on SCK rise, high nibble first; quad_tx=1 drives DQ[3:0], tris 4'b0000; quad_tx=0 tris 4'b1111.
REQ-020 Bit count SHALL advance by 1 (x1) or 4 (x4) per SCK rise, 4-bit, byte complete when it reaches 8, then wrap to 0.
REQ-021 rx_valid SHALL pulse one cycle, exactly 1 cycle after the detect cycle of the byte-completing SCK rise, with rx_data updated same cycle.
REQ-022 In that same cycle: capture tx_data into tx shift register, re-latch quad_mode/quad_tx; tx_req pulses the following cycle.
REQ-023 Outputs SHALL update 1 cycle after SCK-fall detect cycle (next bit/nibble); first bit of each byte from the captured value.
REQ-024 SCK edges while IDLE SHALL be ignored; no rx_valid/tx_req outside ACTIVE.
REQ-025 CS deassert mid-byte: partial byte discarded, no rx_valid, frame_end pulse, tris 4'b1111, count 0.
REQ-026 CS deassert and SCK edge in same detect cycle: CS wins, edge ignored.
REQ-027 Mode changes from quad_mode/quad_tx SHALL take effect only at frame start or byte boundary.

Reset
REQ-028 On rst_n low (any time, incl. mid-frame): state IDLE, qspi_dq_out 4'b0000, qspi_dq_tris 4'b1111, rx_data 8'h00, rx_valid/tx_req/frame_start/frame_end 0, count 0, synchronizers cleared to CS_n=1, SCK=0, DQ=0.
REQ-029 After rst_n release, a frame SHALL begin only on a fresh CS_n falling edge (CS already low at release SHALL NOT start a frame).

Structure
REQ-030 Package qspi_pkg SHALL hold tris constants (TRIS_IDLE 4'b1111, TRIS_X1 4'b1101, TRIS_X4_OUT 4'b0000) and the state enum.
REQ-031 One sub-module qspi_input_sync (parameterized width/stages, async active-low reset with per-bit reset value) SHALL synchronize pins.

Verification
REQ-032 x1, CS low, host shifts 8'hA5 on DQ0, tx_data=8'h3C -> rx_valid once, rx_data 8'hA5; DQ1 carries 0,0,1,1,1,1,0,0; tris 4'b1101.
REQ-033 x4 rx, quad_tx=0, host sends nibbles 4'hD,4'hE,4'hA,4'hD -> two rx_valid, 8'hDE then 8'hAD; tris 4'b1111.
REQ-034 x4 tx, quad_tx=1, tx_data 8'h5A then 8'hC3 after tx_req -> DQ sequence 5,A,C,3; tx_req pulses 3 times (start + 2 boundaries).
REQ-035 CS deasserted after 5 SCK rises -> no rx_valid, frame_end pulse, tris 4'b1111; next frame byte 8'h81 received correctly.
REQ-036 rst_n asserted mid-byte with CS held low -> all outputs at reset values; no frame until CS_n toggles high then low.
REQ-037 x1 byte 8'h01 then quad_mode=1 -> second byte received as x4 (2 rises); quad_mode change mid-byte has no effect until boundary.
